// File: rtl/muldiv_seq.sv
`default_nettype none
// muldiv_seq - iterative RV32M shift-add multiply / restoring divide; rev 1.0
// Divide/remainder datapath is compiled in only when MULDIV_DIV_EN is defined.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             start,
  input  logic [3:0]       muldivcont,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIXUP, S_DONE} state_t;

  state_t               r_state, w_next;
  logic [CW-1:0]        r_cnt;
  logic [2*WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]     r_opb;
  logic [2:0]           r_op;
  logic                 r_neg;
  logic                 r_done, r_busy;
  logic [WIDTH-1:0]     r_result;

  logic                 w_accept, w_is_div, w_legal, w_special;
  logic                 w_sa, w_sb, w_na, w_nb, w_neg;
  logic [WIDTH-1:0]     w_absa, w_absb, w_special_res, w_fix, w_mul_res;
  logic [WIDTH:0]       w_sum;
  logic [2*WIDTH-1:0]   w_mul_next, w_step, w_acc_neg;

  assign w_accept = start && !flush && (r_state == S_IDLE || r_state == S_DONE);
  assign w_is_div = muldivcont[2];

  // Signedness: MUL/MULH/MULHSU treat a as signed, only MUL/MULH treat b as
  // signed; DIV/REM (op[0]==0) are signed on both operands.
  assign w_sa   = w_is_div ? !muldivcont[0] : (muldivcont[1:0] != 2'b11);
  assign w_sb   = w_is_div ? !muldivcont[0] : !muldivcont[1];
  assign w_na   = w_sa & src1[WIDTH-1];
  assign w_nb   = w_sb & src2[WIDTH-1];
  assign w_absa = w_na ? -src1 : src1;
  assign w_absb = w_nb ? -src2 : src2;
  assign w_neg  = (w_is_div && muldivcont[1]) ? w_na : (w_na ^ w_nb);

  assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_opb};
  assign w_mul_next = r_acc[0] ? {w_sum, r_acc[WIDTH-1:1]} : {1'b0, r_acc[2*WIDTH-1:1]};
  assign w_acc_neg  = -r_acc;
  assign w_mul_res  = (r_op[1:0] == 2'b00)
                    ? (r_neg ? w_acc_neg[WIDTH-1:0]       : r_acc[WIDTH-1:0])
                    : (r_neg ? w_acc_neg[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH]);

`ifdef MULDIV_DIV_EN
  logic             w_divz, w_ovf;
  logic [WIDTH:0]   w_shift, w_diff;
  logic [2*WIDTH-1:0] w_div_next;
  logic [WIDTH-1:0] w_lo, w_hi, w_div_res;

  assign w_legal = !muldivcont[3];
  assign w_divz  = w_legal && w_is_div && (src2 == '0);
  assign w_ovf   = w_legal && w_is_div && !muldivcont[0] &&
                   (src1 == {1'b1, {(WIDTH-1){1'b0}}}) && (src2 == '1);
  assign w_special = !w_legal || w_divz || w_ovf;
  assign w_special_res = !w_legal ? '0 :
                         w_divz   ? (muldivcont[1] ? src1 : '1) :
                         w_ovf    ? (muldivcont[1] ? '0 : {1'b1, {(WIDTH-1){1'b0}}}) : '0;

  // Upper half is the partial remainder, lower half the dividend/quotient.
  assign w_shift    = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_diff     = w_shift - {1'b0, r_opb};
  assign w_div_next = w_diff[WIDTH] ? {w_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                    : {w_diff[WIDTH-1:0],  r_acc[WIDTH-2:0], 1'b1};
  assign w_step     = r_op[2] ? w_div_next : w_mul_next;

  assign w_lo      = r_acc[WIDTH-1:0];
  assign w_hi      = r_acc[2*WIDTH-1:WIDTH];
  assign w_div_res = r_op[1] ? (r_neg ? -w_hi : w_hi) : (r_neg ? -w_lo : w_lo);
  assign w_fix     = r_op[2] ? w_div_res : w_mul_res;
`else
  assign w_legal       = !muldivcont[3] && !muldivcont[2];
  assign w_special     = !w_legal;
  assign w_special_res = '0;
  assign w_step        = w_mul_next;
  assign w_fix         = r_op[2] ? '0 : w_mul_res;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = w_special ? S_DONE : S_CALC;
      S_CALC:  if (r_cnt == CW'(1)) w_next = S_FIXUP;
      S_FIXUP: w_next = S_DONE;
      S_DONE:  w_next = w_accept ? (w_special ? S_DONE : S_CALC) : S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (flush) w_next = S_IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_opb    <= '0;
      r_op     <= '0;
      r_neg    <= 1'b0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
      r_result <= '0;
    end else begin
      r_state <= w_next;
      r_done  <= (w_next == S_DONE);
      r_busy  <= (w_next == S_CALC) || (w_next == S_FIXUP);
      if (w_accept) begin
        r_op  <= muldivcont[2:0];
        r_neg <= w_neg;
        r_cnt <= CW'(WIDTH);
        r_acc <= {{WIDTH{1'b0}}, (w_is_div ? w_absa : w_absb)};
        r_opb <= w_is_div ? w_absb : w_absa;
        if (w_special) r_result <= w_special_res;
      end else if (r_state == S_CALC && !flush) begin
        r_acc <= w_step;
        r_cnt <= r_cnt - CW'(1);
      end else if (r_state == S_FIXUP && !flush) begin
        r_result <= w_fix;
      end
    end
  end

  assign stall  = w_accept || (r_state == S_CALC) || (r_state == S_FIXUP);
  assign done   = r_done;
  assign busy   = r_busy;
  assign result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_seq.sv
`default_nettype none
// tb_muldiv_seq - randomized + directed self-checking bench for muldiv_seq; rev 1.0
// Honours MULDIV_DIV_EN the same way the design does.
module tb_muldiv_seq;
  localparam int WIDTH = 32;

  logic        clk = 1'b0;
  logic        reset, flush, start;
  logic [3:0]  muldivcont;
  logic [31:0] src1, src2;
  logic        stall, done, busy;
  logic [31:0] result;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] last_res = '0;

  muldiv_seq #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .flush(flush), .start(start),
    .muldivcont(muldivcont), .src1(src1), .src2(src2),
    .stall(stall), .done(done), .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic bit div_enabled();
`ifdef MULDIV_DIV_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit is_special(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[3]) return 1'b1;
    if (op >= 4'd4) begin
      if (!div_enabled()) return 1'b1;
      if (b == 32'd0) return 1'b1;
      if ((op == 4'd4 || op == 4'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] sxa, sxb, zxa, zxb, p;
    int sa, sb;
    bit ovf;
    sxa = {{32{a[31]}}, a}; sxb = {{32{b[31]}}, b};
    zxa = {32'd0, a};       zxb = {32'd0, b};
    sa = $signed(a);        sb = $signed(b);
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      4'd0: begin p = zxa * zxb; return p[31:0];  end
      4'd1: begin p = sxa * sxb; return p[63:32]; end
      4'd2: begin p = sxa * zxb; return p[63:32]; end
      4'd3: begin p = zxa * zxb; return p[63:32]; end
      4'd4: if (!div_enabled()) return 32'd0; else if (b == 0) return 32'hFFFF_FFFF;
            else if (ovf) return 32'h8000_0000; else return 32'(sa / sb);
      4'd5: if (!div_enabled()) return 32'd0; else if (b == 0) return 32'hFFFF_FFFF;
            else return a / b;
      4'd6: if (!div_enabled()) return 32'd0; else if (b == 0) return a;
            else if (ovf) return 32'd0; else return 32'(sa % sb);
      4'd7: if (!div_enabled()) return 32'd0; else if (b == 0) return a;
            else return a % b;
      default: return 32'd0;
    endcase
  endfunction

  // Called at a negedge with the sequencer in IDLE or DONE; returns at the
  // negedge of the DONE cycle.
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
    int ns = 0;
    int nb = 0;
    bit got = 1'b0;
    bit sp;
    logic [31:0] exp;
    exp = ref_model(op, a, b);
    sp  = is_special(op, a, b);
    muldivcont = op; src1 = a; src2 = b; start = 1'b1;
    for (int k = 0; k < 60 && !got; k++) begin
      #1;
      if (stall) ns++;
      if (busy)  nb++;
      @(negedge clk);
      start = 1'b0;
      if (done) got = 1'b1;
    end
    check_val({tag, " done"},  32'(got), 32'd1);
    check_val({tag, " stall"}, 32'(ns), sp ? 32'd1 : 32'd34);
    check_val({tag, " busy"},  32'(nb), sp ? 32'd0 : 32'd33);
    check_val({tag, " result"}, result, exp);
    last_res = exp;
  endtask

  task automatic after_op(input string tag);
    @(negedge clk);
    check_val({tag, " pulse"}, 32'(done), 32'd0);
    check_val({tag, " hold"}, result, last_res);
  endtask

  logic [3:0]  d_op [15] = '{4'd0, 4'd3, 4'd1, 4'd2, 4'd4, 4'd6, 4'd5, 4'd7,
                             4'd4, 4'd6, 4'd4, 4'd6, 4'd5, 4'd8, 4'd15};
  logic [31:0] d_a  [15] = '{32'd7, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF,
                             32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100,
                             32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'd9,
                             32'h1234, 32'hDEAD_BEEF};
  logic [31:0] d_b  [15] = '{32'd6, 32'hFFFF_FFFF, 32'h8000_0000, 32'd2,
                             32'd2, 32'd2, 32'd7, 32'd7, 32'd0, 32'd0,
                             32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd3, 32'd5, 32'd1};
  logic [31:0] corners [4] = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000};

  initial begin
    bit seen;
    logic [3:0]  rop;
    logic [31:0] ra, rb;
    reset = 1'b1; flush = 1'b0; start = 1'b0;
    muldivcont = '0; src1 = '0; src2 = '0;
    #12;
    check_val("reset result", result, 32'd0);
    check_val("reset done",   32'(done),  32'd0);
    check_val("reset busy",   32'(busy),  32'd0);
    check_val("reset stall",  32'(stall), 32'd0);
    @(negedge clk); reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 15; i++) begin
      do_op(d_op[i], d_a[i], d_b[i], $sformatf("dir%0d", i));
      after_op($sformatf("dir%0d", i));
    end

    // start held through DONE: second op begins without an IDLE cycle
    @(negedge clk);
    do_op(4'd0, 32'd3, 32'd5, "b2b first");
    do_op(4'd3, 32'h1234_5678, 32'h9ABC_DEF0, "b2b second");
    after_op("b2b");

    // flush in the middle of a multiply
    @(negedge clk);
    muldivcont = 4'd0; src1 = 32'd123; src2 = 32'd456; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    #1;
    check_val("flush busy",  32'(busy),  32'd0);
    check_val("flush stall", 32'(stall), 32'd0);
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check_val("flush no done", 32'(seen), 32'd0);
    check_val("flush result",  result, last_res);

    // start and flush together: op dropped
    muldivcont = 4'd0; src1 = 32'd77; src2 = 32'd88; start = 1'b1; flush = 1'b1;
    #1;
    check_val("start+flush stall", 32'(stall), 32'd0);
    @(negedge clk); start = 1'b0; flush = 1'b0;
    check_val("start+flush busy", 32'(busy), 32'd0);
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check_val("start+flush no done", 32'(seen), 32'd0);
    check_val("start+flush result",  result, last_res);

    // randomized ops against the reference model
    for (int i = 0; i < 60; i++) begin
      rop = ($urandom_range(0, 9) >= 8) ? (4'h8 | 4'($urandom_range(0, 7))) : 4'($urandom_range(0, 7));
      ra  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : $urandom;
      if ($urandom_range(0, 4) == 0) rb = 32'($urandom_range(0, 15));
      do_op(rop, ra, rb, $sformatf("rnd%0d op%0d", i, rop));
      if ($urandom_range(0, 2) != 0) after_op($sformatf("rnd%0d", i));
    end
    @(negedge clk);

    // asynchronous reset mid-CALC
    muldivcont = 4'd1; src1 = 32'hCAFE_0001; src2 = 32'h0000_1234; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check_val("async rst result", result, 32'd0);
    check_val("async rst busy",   32'(busy),  32'd0);
    check_val("async rst done",   32'(done),  32'd0);
    check_val("async rst stall",  32'(stall), 32'd0);
    @(negedge clk); reset = 1'b0;
    last_res = 32'd0;
    @(negedge clk);
    do_op(4'd0, 32'd7, 32'd6, "post rst");
    after_op("post rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/muldiv_seq.md
# muldiv_seq

Iterative multiply/divide sequencer for the execute stage. It accepts one RV32M operation from the stage's operand muxes and runs a radix-2 shift-add multiply or restoring divide over WIDTH cycles. While it runs it holds the pipeline with a stall, and it delivers the result alongside the 32-bit ALU result. It lets the execute stage share one narrow arithmetic core for all M-extension ops instead of instantiating a combinational multiplier/divider.

## Interface
- WIDTH, 32: operand/result width; counter is $clog2(WIDTH)+1 bits.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous abort (driven from ExREGclear); beats start.
- start  in  1  operation request, sampled when state is IDLE or DONE.
- muldivcont  in  4  op: 0000 MUL, 0001 MULH, 0010 MULHSU, 0011 MULHU, 0100 DIV, 0101 DIVU, 0110 REM, 0111 REMU; 1xxx illegal.
- src1  in  WIDTH  operand a (rs1), captured on accepted start.
- src2  in  WIDTH  operand b (rs2), captured on accepted start.
- stall  out  1  combinational: start accepted this cycle OR state in {CALC, FIXUP}; drives ExREGstall.
- done  out  1  registered one-cycle pulse; result valid.
- result  out  WIDTH  registered; holds last completed value until next completion.
- busy  out  1  registered: state in {CALC, FIXUP}.

## Operation
- States: IDLE, CALC, FIXUP, DONE. Reset: IDLE, done=0, busy=0, result=0, counter=0, internal registers 0.
- Start is accepted only in IDLE or DONE, and only when flush=0. Start in CALC/FIXUP is ignored (stall is already high).
- On accept: latch op, take |src1|/|src2| per signedness (MULH: both signed; MULHSU: a signed, b unsigned; DIV/REM: both signed), record result sign, load counter=WIDTH, go to CALC.
- Multiply: 2*WIDTH product register. Each CALC cycle: if multiplier LSB is 1, add the multiplicand to the upper half, then shift right 1.
- Divide: remainder/quotient register pair. Each CALC cycle: shift left 1, trial-subtract the divisor; if non-negative, keep the difference and set quotient LSB.
- CALC decrements the counter; at counter==1 it goes to FIXUP. FIXUP applies two's-complement negation per recorded sign and selects low/high half or quotient/remainder, writes result, then goes to DONE.
- DONE: done=1 for exactly this cycle. Next state is CALC if a new start is accepted, otherwise IDLE.
- Divide by zero (src2==0): skip CALC/FIXUP. Quotient = all ones, remainder = src1; go straight to DONE.
- Signed overflow (DIV/REM, src1=0x80000000, src2=0xFFFFFFFF): skip. Quotient = 0x80000000, remainder = 0.
- Illegal op: skip; result = 0.
- flush in any state: next state IDLE, busy=0, done=0 next cycle, result unchanged, no write.
- reset mid-operation: immediate return to reset values regardless of clk.

## Timing
- Start accepted at edge E0 (stall high in cycle before E0).
- Normal op: CALC through edges E1..E32, FIXUP at E33, done high in the cycle after E33. Latency is WIDTH+2 = 34 edges from accept to done.
- Special cases (div-by-zero, overflow, illegal): done high in the cycle after E0. Latency 1.
- stall is low in DONE so the pipeline advances and captures result that cycle. result stays stable after done.
- Back-to-back: start in DONE is accepted. CALC begins the next edge with no IDLE bubble.
- Simultaneous start+flush: flush wins, op dropped.

## Configuration
- MULDIV_DIV_EN defined: divide/remainder path compiled in as above.
- Not defined: no divide datapath. Ops 0100–0111 are treated as illegal: 1-cycle latency, result 0. Multiply behaviour and latency are unchanged.

## Test plan
- MUL 7 × 6 after reset -> stall high 34 cycles, done pulse, result 0x0000002A. MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE.
- MULH 0x80000000 × 0x80000000 -> 0x40000000. MULHSU 0xFFFFFFFF × 2 -> 0xFFFFFFFF.
- DIV −7 / 2 -> 0xFFFFFFFD. REM −7 / 2 -> 0xFFFFFFFF. DIVU 100 / 7 -> 14. REMU -> 2. Each takes 34-cycle latency.
- DIV 5 / 0 -> 0xFFFFFFFF in 1 cycle. REM 5 / 0 -> 5. DIV 0x80000000 / −1 -> 0x80000000. REM of the same -> 0.
- Flush at cycle 10 of a MUL -> IDLE next edge, no done, result keeps prior value. Start+flush same cycle -> ignored.
- Start held high during DONE -> second op begins with no bubble. Reset asserted mid-CALC -> all outputs 0 asynchronously. Without MULDIV_DIV_EN, DIVU 9 / 3 -> 0 in 1 cycle.
